// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and divider helper for the parametrised UART receiver.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_COMMIT,
    S_BRK_WAIT
  } rx_state_e;

  // Clocks per oversample tick; never below 1 so the divider always advances.
  function automatic int calc_div(int clk_freq, int baud_rate, int oversample);
    int d;
    d = clk_freq / (baud_rate * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Consumer-side bundle of the UART receiver: held word, status flags and acknowledge.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  // data_valid is a level that stays high, with uart_data and the error flags stable,
  // until the consumer raises data_ack; the word is taken on the clock edge where both are 1.
  logic [DATA_BITS-1:0] uart_data;
  logic                 data_valid;
  logic                 data_ack;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 break_det;
  logic                 rx_busy;

  modport master (
    output uart_data, data_valid, parity_err, frame_err, overrun_err, break_det, rx_busy,
    input  data_ack
  );

  modport slave (
    input  uart_data, data_valid, parity_err, frame_err, overrun_err, break_det, rx_busy,
    output data_ack
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider; restart_i realigns the phase to a start edge.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart_i || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority vote, optional parity, 1/2 stop bits,
// error/break reporting and a hold-until-acknowledged output word.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   uart_rx,
  uart_rx_param_if.master        rx_if,
  output rx_state_e              dbg_state_o
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_VOTE = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, rx_prev_q;
  rx_state_e            state_q;
  logic [SW-1:0]        samp_q;
  logic [1:0]           vote_q;
  logic [3:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q, par_err_q, frame_bad_q, brk_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, pe_q, fe_q, ovr_q, brk_det_q, busy_q;

  logic rx_s, fall, restart, tick, vote_now, vote_bit;
  logic stop_last, brk_cond, frame_err_now, par_calc, par_err_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= uart_rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_s    = sync2_q;
  assign fall    = rx_prev_q & ~rx_s;
  assign restart = (state_q == S_IDLE) && fall;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // The third sample is the live line value; the two earlier ones sit in vote_q.
  assign vote_now      = tick && (samp_q == SAMP_VOTE);
  assign vote_bit      = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
  assign stop_last     = (STOP_BITS == 1) || stop_cnt_q;
  assign brk_cond      = (shift_q == '0) && ((PARITY == PARITY_NONE) || !par_bit_q) && !vote_bit;
  assign frame_err_now = frame_bad_q | ~vote_bit;
  assign par_calc      = ^{shift_q, vote_bit};
  assign par_err_now   = (PARITY == PARITY_ODD) ? ~par_calc : par_calc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      samp_q      <= '0;
      vote_q      <= 2'b11;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
      frame_bad_q <= 1'b0;
      brk_q       <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
      ovr_q       <= 1'b0;
      brk_det_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      brk_det_q <= 1'b0;
      if (restart) begin
        samp_q <= '0;
      end else if (tick) begin
        samp_q <= (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
      end
      if (tick) begin
        vote_q <= {vote_q[0], rx_s};
      end
      if (valid_q && rx_if.data_ack) begin
        valid_q <= 1'b0;
        pe_q    <= 1'b0;
        fe_q    <= 1'b0;
        ovr_q   <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (fall) state_q <= S_START;
        end
        S_START: begin
          if (vote_now) begin
            if (vote_bit) begin
              state_q <= S_IDLE;
            end else begin
              state_q   <= S_DATA;
              busy_q    <= 1'b1;
              bit_cnt_q <= '0;
            end
          end
        end
        S_DATA: begin
          if (vote_now) begin
            shift_q   <= {vote_bit, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) begin
              state_q     <= (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
              stop_cnt_q  <= 1'b0;
              frame_bad_q <= 1'b0;
            end
          end
        end
        S_PARITY: begin
          if (vote_now) begin
            par_bit_q <= vote_bit;
            par_err_q <= par_err_now;
            state_q   <= S_STOP;
          end
        end
        S_STOP: begin
          if (vote_now) begin
            if (!stop_last) begin
              stop_cnt_q  <= 1'b1;
              frame_bad_q <= ~vote_bit;
              brk_q       <= brk_cond;
            end else begin
              busy_q      <= 1'b0;
              frame_bad_q <= frame_err_now;
              // Break is judged on the first stop bit even when two are configured.
              if ((STOP_BITS == 1) ? brk_cond : brk_q) begin
                state_q   <= S_BRK_WAIT;
                brk_det_q <= 1'b1;
              end else begin
                state_q <= S_COMMIT;
              end
            end
          end
        end
        S_COMMIT: begin
          if (!valid_q || rx_if.data_ack) begin
            data_q  <= shift_q;
            pe_q    <= par_err_q;
            fe_q    <= frame_bad_q;
            ovr_q   <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            ovr_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        S_BRK_WAIT: begin
          if (rx_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_if.uart_data   = data_q;
  assign rx_if.data_valid  = valid_q;
  assign rx_if.parity_err  = pe_q;
  assign rx_if.frame_err   = fe_q;
  assign rx_if.overrun_err = ovr_q;
  assign rx_if.break_det   = brk_det_q;
  assign rx_if.rx_busy     = busy_q;
  assign dbg_state_o       = state_q;
endmodule
